// File: rtl/branch_resolve.sv
// Branch resolution controller: evaluates the comparator result for one control-transfer
// instruction at a time, issues the PC redirect and then holds flush for a fixed window.
module branch_resolve #(
  parameter int DWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_branch,
  input  logic              is_jal,
  input  logic              is_jalr,
  input  logic [2:0]        funct3,
  input  logic [DWIDTH-1:0] pc,
  input  logic [DWIDTH-1:0] imm,
  input  logic [DWIDTH-1:0] rs1_data,
  output logic              BrUn,
  input  logic              BrEq,
  input  logic              BrLt,
  output logic              resolve_valid,
  output logic              resolve_taken,
  output logic              redirect_valid,
  output logic [DWIDTH-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              flush,
  output logic              err_illegal,
  output logic              err_misalign,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]   FC_LOAD    = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [DWIDTH-1:0] ALIGN_MASK = {{(DWIDTH-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT, FLUSH} state_t;

  state_t            state, stateNext;
  logic [FC_W-1:0]   flushCnt;
  logic              isBranchQ, isJalQ, isJalrQ;
  logic [2:0]        funct3Q;
  logic [DWIDTH-1:0] pcQ, immQ, rs1Q;

  logic              condTaken, illegalF3, rawTaken, taken, misalign, illegalHit;
  logic [DWIDTH-1:0] target;

  assign in_ready = (state == IDLE);

  // Decision logic only matters while in RESOLVE; operands come from the latched copy.
  always_comb begin
    condTaken = 1'b0;
    illegalF3 = 1'b0;
    case (funct3Q)
      3'b000:         condTaken = BrEq;
      3'b001:         condTaken = !BrEq;
      3'b100, 3'b110: condTaken = BrLt;
      3'b101, 3'b111: condTaken = !BrLt;
      default:        illegalF3 = 1'b1;
    endcase
    target     = isJalrQ ? ((rs1Q + immQ) & ALIGN_MASK) : (pcQ + immQ);
    rawTaken   = isJalQ | isJalrQ | (isBranchQ & condTaken);
    illegalHit = isBranchQ & illegalF3;
    misalign   = rawTaken & target[1];
    taken      = rawTaken & !target[1];
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (in_valid) stateNext = RESOLVE;
      RESOLVE:  stateNext = taken ? REDIRECT : IDLE;
      REDIRECT: if (redirect_ready) stateNext = FLUSH;
      FLUSH:    if (flushCnt == '0) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      flushCnt       <= '0;
      isBranchQ      <= 1'b0;
      isJalQ         <= 1'b0;
      isJalrQ        <= 1'b0;
      funct3Q        <= '0;
      pcQ            <= '0;
      immQ           <= '0;
      rs1Q           <= '0;
      BrUn           <= 1'b0;
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      err_illegal    <= 1'b0;
      err_misalign   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      br_count       <= '0;
      taken_count    <= '0;
    end else begin
      state          <= stateNext;
      resolve_valid  <= (state == RESOLVE);
      resolve_taken  <= (state == RESOLVE) && taken;
      err_illegal    <= (state == RESOLVE) && illegalHit;
      err_misalign   <= (state == RESOLVE) && misalign;
      redirect_valid <= (stateNext == REDIRECT);
      flush          <= (stateNext == FLUSH);

      if (state == IDLE && in_valid) begin
        isBranchQ <= is_branch;
        isJalQ    <= is_jal;
        isJalrQ   <= is_jalr;
        funct3Q   <= funct3;
        pcQ       <= pc;
        immQ      <= imm;
        rs1Q      <= rs1_data;
        BrUn      <= funct3[1];
      end

      // Target is captured once and held for the whole redirect handshake.
      if (state == RESOLVE && taken) redirect_pc <= target;

      if (state == REDIRECT)                   flushCnt <= FC_LOAD;
      else if (state == FLUSH && flushCnt != '0) flushCnt <= flushCnt - 1'b1;

      if (state == RESOLVE) begin
        if (br_count != CNT_MAX)           br_count    <= br_count + 1'b1;
        if (taken && taken_count != CNT_MAX) taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a spec-level decision model plus a per-cycle compare
// process, with literal checks on the listed scenarios.
module tb_branch_resolve;

  localparam int DW   = 32;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [DW-1:0] pc = '0, imm = '0, rs1_data = '0;
  logic          BrUn, BrEq, BrLt;
  logic          resolve_valid, resolve_taken, redirect_valid, redirect_ready = 1'b0;
  logic [DW-1:0] redirect_pc;
  logic          flush, err_illegal, err_misalign;
  logic [CW-1:0] br_count, taken_count;
  logic [DW-1:0] opA = '0, opB = '0;

  int total = 0, bad = 0;
  int rdyDelay = 0, waitCnt = 0;

  always #5 clk = ~clk;

  // Comparator stand-in driven by the DUT's BrUn.
  assign BrEq = (opA == opB);
  assign BrLt = BrUn ? (opA < opB) : ($signed(opA) < $signed(opB));

  branch_resolve #(.DWIDTH(DW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .pc(pc), .imm(imm), .rs1_data(rs1_data), .BrUn(BrUn), .BrEq(BrEq), .BrLt(BrLt),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush), .err_illegal(err_illegal),
    .err_misalign(err_misalign), .br_count(br_count), .taken_count(taken_count)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic failNote(input string nm);
    total++;
    bad++;
    $display("FAIL %s timed out at %0t", nm, $time);
  endtask

  typedef struct packed {
    logic          taken;
    logic          illegal;
    logic          misalign;
    logic [DW-1:0] target;
  } exp_t;

  function automatic exp_t decide(input logic b, input logic j, input logic jr,
                                  input logic [2:0] f3, input logic [DW-1:0] p,
                                  input logic [DW-1:0] im, input logic [DW-1:0] r1,
                                  input logic [DW-1:0] a, input logic [DW-1:0] bb);
    exp_t e;
    logic raw;
    e = '0;
    raw = 1'b0;
    e.target = jr ? ((r1 + im) & 32'hFFFF_FFFE) : (p + im);
    if (j || jr) raw = 1'b1;
    else if (b) begin
      case (f3)
        3'd0: raw = (a == bb);
        3'd1: raw = (a != bb);
        3'd4: raw = ($signed(a) < $signed(bb));
        3'd5: raw = !($signed(a) < $signed(bb));
        3'd6: raw = (a < bb);
        3'd7: raw = !(a < bb);
        default: e.illegal = 1'b1;
      endcase
    end
    e.misalign = raw && e.target[1];
    e.taken    = raw && !e.target[1];
    return e;
  endfunction

  // Fetch side: hold redirect_ready low for rdyDelay cycles of each redirect.
  always @(posedge clk) begin
    #1;
    if (redirect_valid) begin
      if (waitCnt >= rdyDelay) redirect_ready = 1'b1;
      else begin
        redirect_ready = 1'b0;
        waitCnt++;
      end
    end else begin
      redirect_ready = 1'b0;
      waitCnt = 0;
    end
  end

  // Per-cycle compare against the model.
  exp_t q[$];
  exp_t e;
  logic accPrev = 0, resPrev = 0, redirPend = 0, expBrUn = 0;
  logic rslvNow, resNow, flushNow;
  logic [DW-1:0] expPc = '0;
  int flushLeft = 0, mBr = 0, mTk = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      accPrev = 0; resPrev = 0; redirPend = 0; expBrUn = 0;
      flushLeft = 0; mBr = 0; mTk = 0; expPc = '0;
    end else begin
      rslvNow  = accPrev;
      resNow   = resPrev;
      flushNow = (flushLeft > 0);
      e = '0;
      if (resNow) begin
        if (q.size() == 0) failNote("model_queue");
        else e = q.pop_front();
        if (mBr < CMAX) mBr++;
        if (e.taken && mTk < CMAX) mTk++;
        redirPend = e.taken;
        if (e.taken) expPc = e.target;
      end
      chk("resolve_valid", resolve_valid, resNow);
      chk("resolve_taken", resolve_taken, e.taken);
      chk("err_illegal", err_illegal, e.illegal);
      chk("err_misalign", err_misalign, e.misalign);
      chk("redirect_valid", redirect_valid, redirPend);
      if (redirPend) chk("redirect_pc", redirect_pc, expPc);
      chk("flush", flush, flushNow);
      chk("in_ready", in_ready, !(rslvNow || redirPend || flushNow));
      chk("BrUn", BrUn, expBrUn);
      chk("br_count", br_count, mBr);
      chk("taken_count", taken_count, mTk);
      if (flushNow) flushLeft--;
      if (redirPend && redirect_ready) begin
        redirPend = 0;
        flushLeft = FC;
      end
      resPrev = rslvNow;
      accPrev = in_valid && in_ready;
      if (accPrev) begin
        q.push_back(decide(is_branch, is_jal, is_jalr, funct3, pc, imm, rs1_data, opA, opB));
        expBrUn = funct3[1];
      end
    end
  end

  task automatic issue(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                       input logic [DW-1:0] p, input logic [DW-1:0] im,
                       input logic [DW-1:0] r1, input logic [DW-1:0] a,
                       input logic [DW-1:0] bb, input int dly);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) failNote("issue_wait");
    is_branch = b; is_jal = j; is_jalr = jr; funct3 = f3;
    pc = p; imm = im; rs1_data = r1; opA = a; opB = bb;
    rdyDelay = dly;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitRes();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resolve_valid && n < 10);
    if (!resolve_valid) failNote("resolve_wait");
  endtask

  task automatic checkResetState(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_resolve_valid"}, resolve_valid, 0);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_errs"}, {err_illegal, err_misalign}, 0);
    chk({tag, "_br_count"}, br_count, 0);
    chk({tag, "_taken_count"}, taken_count, 0);
    chk({tag, "_BrUn"}, BrUn, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int rv, fl;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkResetState("reset");

    // BNE then BEQ with equal operands
    issue(1, 0, 0, 3'b001, 32'h0100, 32'h20, 0, 32'd10, 32'd10, 0);
    waitRes();
    chk("bne_taken", resolve_taken, 0);
    issue(1, 0, 0, 3'b000, 32'h0200, 32'hFFFF_FFF8, 0, 32'd10, 32'd10, 0);
    waitRes();
    chk("beq_taken", resolve_taken, 1);
    chk("beq_pc", redirect_pc, 32'h01F8);
    chk("beq_br_count", br_count, 2);
    chk("beq_taken_count", taken_count, 1);

    // BLT vs BLTU, A=-20, B=10
    issue(1, 0, 0, 3'b100, 32'h0100, 32'h20, 0, -32'sd20, 32'd10, 0);
    waitRes();
    chk("blt_BrUn", BrUn, 0);
    chk("blt_BrLt", BrLt, 1);
    chk("blt_taken", resolve_taken, 1);
    chk("blt_pc", redirect_pc, 32'h0120);
    issue(1, 0, 0, 3'b110, 32'h0100, 32'h20, 0, -32'sd20, 32'd10, 0);
    waitRes();
    chk("bltu_BrUn", BrUn, 1);
    chk("bltu_BrLt", BrLt, 0);
    chk("bltu_taken", resolve_taken, 0);
    chk("bltu_redirect", redirect_valid, 0);

    // BGE signed not-taken, BGEU taken
    issue(1, 0, 0, 3'b101, 32'h0400, 32'h10, 0, 32'hFFFF_FFFF, 32'd1, 0);
    waitRes();
    chk("bge_taken", resolve_taken, 0);
    issue(1, 0, 0, 3'b111, 32'h0400, 32'h10, 0, 32'hFFFF_FFFF, 32'd1, 0);
    waitRes();
    chk("bgeu_taken", resolve_taken, 1);
    chk("bgeu_pc", redirect_pc, 32'h0410);

    // JALR misaligned then aligned
    issue(0, 0, 1, 3'b000, 32'h0, 32'd4, 32'h1003, 0, 0, 0);
    waitRes();
    chk("jalr_mis_err", err_misalign, 1);
    chk("jalr_mis_taken", resolve_taken, 0);
    chk("jalr_mis_redirect", redirect_valid, 0);
    issue(0, 0, 1, 3'b000, 32'h0, 32'd1, 32'h1003, 0, 0, 0);
    waitRes();
    chk("jalr_taken", resolve_taken, 1);
    chk("jalr_pc", redirect_pc, 32'h1004);

    // Misaligned taken branch target
    issue(1, 0, 0, 3'b000, 32'h0100, 32'h2, 0, 32'd5, 32'd5, 0);
    waitRes();
    chk("beq_mis_err", err_misalign, 1);
    chk("beq_mis_redirect", redirect_valid, 0);

    // JAL with redirect_ready low for 3 cycles
    issue(0, 1, 0, 3'b000, 32'h0300, 32'h40, 0, 0, 0, 3);
    waitRes();
    chk("jal_pc", redirect_pc, 32'h0340);
    rv = 0;
    while (redirect_valid && rv < 50) begin
      rv++;
      @(negedge clk);
    end
    fl = 0;
    while (flush && fl < 50) begin
      fl++;
      @(negedge clk);
    end
    chk("jal_redirect_cycles", rv, 4);
    chk("jal_flush_cycles", fl, FC);
    chk("jal_ready_after_flush", in_ready, 1);

    // Illegal funct3 and classless instruction
    issue(1, 0, 0, 3'b010, 32'h0100, 32'h20, 0, 32'd1, 32'd1, 0);
    waitRes();
    chk("illegal_err", err_illegal, 1);
    chk("illegal_taken", resolve_taken, 0);
    chk("illegal_idle", in_ready, 1);
    issue(0, 0, 0, 3'b000, 32'h0100, 32'h20, 0, 32'd1, 32'd1, 0);
    waitRes();
    chk("noclass_taken", resolve_taken, 0);
    chk("noclass_errs", {err_illegal, err_misalign}, 0);

    // Reset while waiting in REDIRECT
    issue(0, 1, 0, 3'b000, 32'h0600, 32'h40, 0, 0, 0, 20);
    waitRes();
    chk("pre_reset_redirect", redirect_valid, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkResetState("midreset");
    issue(1, 0, 0, 3'b000, 32'h0700, 32'h8, 0, 32'd3, 32'd3, 0);
    waitRes();
    chk("post_reset_taken", resolve_taken, 1);
    chk("post_reset_pc", redirect_pc, 32'h0708);
    chk("post_reset_br", br_count, 1);
    chk("post_reset_tk", taken_count, 1);

    // Counter saturation
    for (int i = 0; i < 16; i++) begin
      issue(1, 0, 0, 3'b000, 32'h0500, 32'h8, 0, 32'd7, 32'd7, 0);
      waitRes();
    end
    repeat (6) @(negedge clk);
    chk("sat_br_count", br_count, CMAX);
    chk("sat_taken_count", taken_count, CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
